// File: rtl/digit_render.sv
// Two-stage glyph renderer: block coordinates -> character cell -> font bit and palette colour.
// Font and palette images are compiled in and mirror the default font.hex / color.hex contents.
module digit_render #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned FONT_W       = 3,
  parameter int unsigned FONT_H       = 5,
  parameter              FONT_FILE    = "font.hex",
  parameter              PALETTE_FILE = "color.hex",
  parameter int unsigned CYCLE_FRAMES = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          pix_valid,
  input  logic [5:0]                    x_block,
  input  logic [5:0]                    y_block,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          cycle_en,
  input  logic                          frame_start,
  output logic                          out_valid,
  output logic                          pixel_on,
  output logic [5:0]                    color,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel
);

  localparam int unsigned CELL_W     = FONT_W + 1;
  localparam int unsigned SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned GLYPH_BITS = FONT_W * FONT_H;
  localparam int unsigned IDX_W      = $clog2(GLYPH_BITS);
  localparam int unsigned CC_W       = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam int unsigned BC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (NUM_DIGITS * CELL_W > 64) begin : g_err_cells
    $error("digit_render: NUM_DIGITS*(FONT_W+1) exceeds the 64-block row");
  end
  if (FONT_W != 3 || FONT_H != 5) begin : g_err_font
    $error("digit_render: compiled-in font is 3x5 only");
  end
  if (FONT_FILE != "font.hex" || PALETTE_FILE != "color.hex") begin : g_err_file
    $error("digit_render: only the default compiled-in font/palette images are available");
  end
  if (CYCLE_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_err_frames
    $error("digit_render: CYCLE_FRAMES and BLINK_FRAMES must be at least 1");
  end

  // Glyph rows packed row 0 first (MSBs), each row MSB = leftmost column.
  function automatic logic [GLYPH_BITS-1:0] glyph_rows(input logic [3:0] g);
    case (g)
      4'd0:    glyph_rows = 15'b111_101_101_101_111;
      4'd1:    glyph_rows = 15'b010_110_010_010_111;
      4'd2:    glyph_rows = 15'b111_001_111_100_111;
      4'd3:    glyph_rows = 15'b111_001_111_001_111;
      4'd4:    glyph_rows = 15'b101_101_111_001_001;
      4'd5:    glyph_rows = 15'b111_100_111_001_111;
      4'd6:    glyph_rows = 15'b111_100_111_101_111;
      4'd7:    glyph_rows = 15'b111_001_001_001_001;
      4'd8:    glyph_rows = 15'b111_101_111_101_111;
      4'd9:    glyph_rows = 15'b111_101_111_001_111;
      4'd10:   glyph_rows = 15'b000_010_000_010_000;
      4'd11:   glyph_rows = 15'b000_000_111_000_000;
      4'd12:   glyph_rows = 15'b111_100_100_100_111;
      4'd13:   glyph_rows = 15'b001_001_111_101_111;
      4'd14:   glyph_rows = 15'b111_100_111_100_111;
      default: glyph_rows = 15'b000_000_000_000_000;
    endcase
  endfunction

  function automatic logic [5:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 6'b110000;
      3'd1:    palette = 6'b111100;
      3'd2:    palette = 6'b001100;
      3'd3:    palette = 6'b001111;
      3'd4:    palette = 6'b000011;
      3'd5:    palette = 6'b110011;
      3'd6:    palette = 6'b111111;
      default: palette = 6'b101010;
    endcase
  endfunction

  logic [CC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [2:0]       color_phase_q, color_phase_d;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic             s1_valid_q, s1_valid_d;
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;
  logic [5:0]       s1_col_q, s1_col_d;
  logic [5:0]       s1_row_q, s1_row_d;
  logic             s1_in_glyph_q, s1_in_glyph_d;
  logic             s1_blank_q, s1_blank_d;
  logic [3:0]       s1_code_q, s1_code_d;
  logic [2:0]       s1_pal_q, s1_pal_d;

  logic             pixel_on_d;
  logic [5:0]       color_d;
  logic [SEL_W-1:0] digit_sel_d;

  logic [5:0]       k_c, col_c;
  logic             in_range_c, all_zero_c;
  logic [GLYPH_BITS-1:0] glyph_c;
  logic [IDX_W-1:0] bit_idx_c;
  logic             font_bit_c;

  // Frame counters: colour phase steps every CYCLE_FRAMES enabled frames, blink every BLINK_FRAMES.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    color_phase_d = color_phase_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start && cycle_en) begin
      if (cycle_cnt_q == CC_W'(CYCLE_FRAMES - 1)) begin
        cycle_cnt_d   = '0;
        color_phase_d = color_phase_q + 3'd1;
      end else begin
        cycle_cnt_d = cycle_cnt_q + CC_W'(1);
      end
    end
    if (frame_start) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end

  // Stage 1: cell decode, blanking and glyph code; holds when no pixel is presented.
  always_comb begin
    k_c           = x_block / 6'(CELL_W);
    col_c         = x_block % 6'(CELL_W);
    in_range_c    = 32'(k_c) < NUM_DIGITS;
    all_zero_c    = 1'b1;
    s1_valid_d    = pix_valid;
    s1_sel_d      = s1_sel_q;
    s1_col_d      = s1_col_q;
    s1_row_d      = s1_row_q;
    s1_in_glyph_d = s1_in_glyph_q;
    s1_blank_d    = s1_blank_q;
    s1_code_d     = s1_code_q;
    s1_pal_d      = s1_pal_q;
    if (pix_valid) begin
      s1_sel_d      = in_range_c ? SEL_W'(k_c) : SEL_W'(NUM_DIGITS - 1);
      s1_col_d      = col_c;
      s1_row_d      = y_block;
      s1_in_glyph_d = in_range_c && (32'(col_c) < FONT_W) && (32'(y_block) < FONT_H);
      s1_pal_d      = 3'(k_c) + color_phase_q;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
        all_zero_c = all_zero_c & (digits[4*j +: 4] == 4'd0);
        if (SEL_W'(j) == s1_sel_d) begin
          s1_code_d  = digits[4*j +: 4];
          s1_blank_d = (blink_phase_q & blink_mask[j]) |
                       (LZ_BLANK & all_zero_c & (j < NUM_DIGITS - 1));
        end
      end
    end
  end

  // Stage 2: font bit, palette colour and saturated cell index.
  always_comb begin
    glyph_c     = glyph_rows(s1_code_q);
    bit_idx_c   = IDX_W'(GLYPH_BITS - 1 - (32'(s1_row_q) * FONT_W + 32'(s1_col_q)));
    font_bit_c  = s1_in_glyph_q ? glyph_c[bit_idx_c] : 1'b0;
    pixel_on_d  = pixel_on;
    color_d     = color;
    digit_sel_d = digit_sel;
    if (s1_valid_q) begin
      pixel_on_d  = s1_in_glyph_q & ~s1_blank_q & font_bit_c;
      color_d     = palette(s1_pal_q);
      digit_sel_d = s1_sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q   <= '0;
      color_phase_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_sel_q      <= '0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_in_glyph_q <= 1'b0;
      s1_blank_q    <= 1'b0;
      s1_code_q     <= '0;
      s1_pal_q      <= '0;
      out_valid     <= 1'b0;
      pixel_on      <= 1'b0;
      color         <= '0;
      digit_sel     <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      color_phase_q <= color_phase_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s1_valid_q    <= s1_valid_d;
      s1_sel_q      <= s1_sel_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_in_glyph_q <= s1_in_glyph_d;
      s1_blank_q    <= s1_blank_d;
      s1_code_q     <= s1_code_d;
      s1_pal_q      <= s1_pal_d;
      out_valid     <= s1_valid_q;
      pixel_on      <= pixel_on_d;
      color         <= color_d;
      digit_sel     <= digit_sel_d;
    end
  end

endmodule

// File: tb/tb_digit_render.sv
// Directed bench for digit_render: vector table plus colour, blink, coincidence and reset sequences.
module tb_digit_render;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_valid;
  logic [5:0]  x_block, y_block;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic        cycle_en, frame_start;
  logic        out_valid, pixel_on;
  logic [5:0]  color;
  logic [1:0]  digit_sel;

  int total = 0;
  int bad   = 0;

  logic [5:0] pal [0:7];

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] dig;
    logic        exp_on;
    logic [1:0]  exp_sel;
    logic [2:0]  exp_pal;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [0:NV-1];

  digit_render #(.CYCLE_FRAMES(2), .BLINK_FRAMES(3)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .x_block(x_block),
    .y_block(y_block), .digits(digits), .blink_mask(blink_mask), .cycle_en(cycle_en),
    .frame_start(frame_start), .out_valid(out_valid), .pixel_on(pixel_on),
    .color(color), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; frame_start = 1'b0; cycle_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Single isolated pixel: checks the 2-cycle latency and the output fields.
  task automatic one_pixel(input string nm, input logic [5:0] x, input logic [5:0] y,
                           input logic exp_on, input logic [1:0] exp_sel, input logic [5:0] exp_col);
    x_block = x; y_block = y; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk({nm, " lat1 valid"}, 8'(out_valid), 8'd0);
    @(posedge clk); #1;
    chk({nm, " valid"}, 8'(out_valid), 8'd1);
    chk({nm, " on"}, 8'(pixel_on), 8'(exp_on));
    chk({nm, " sel"}, 8'(digit_sel), 8'(exp_sel));
    chk({nm, " color"}, 8'(color), 8'(exp_col));
  endtask

  initial begin
    logic [15:0] scan_exp;
    pal[0] = 6'b110000; pal[1] = 6'b111100; pal[2] = 6'b001100; pal[3] = 6'b001111;
    pal[4] = 6'b000011; pal[5] = 6'b110011; pal[6] = 6'b111111; pal[7] = 6'b101010;

    // digit k sits at digits[4k+3:4k]; 16'h8000 is digit3=8 with digits 0..2 zero
    vt[0]  = '{6'd0,  6'd0, 16'h8000, 1'b0, 2'd0, 3'd0};
    vt[1]  = '{6'd0,  6'd1, 16'h8000, 1'b0, 2'd0, 3'd0};
    vt[2]  = '{6'd5,  6'd0, 16'h8000, 1'b0, 2'd1, 3'd1};
    vt[3]  = '{6'd9,  6'd4, 16'h8000, 1'b0, 2'd2, 3'd2};
    vt[4]  = '{6'd12, 6'd0, 16'h8000, 1'b1, 2'd3, 3'd3};
    vt[5]  = '{6'd13, 6'd1, 16'h8000, 1'b0, 2'd3, 3'd3};
    vt[6]  = '{6'd14, 6'd1, 16'h8000, 1'b1, 2'd3, 3'd3};
    vt[7]  = '{6'd13, 6'd2, 16'h8000, 1'b1, 2'd3, 3'd3};
    vt[8]  = '{6'd13, 6'd3, 16'h8000, 1'b0, 2'd3, 3'd3};
    vt[9]  = '{6'd13, 6'd4, 16'h8000, 1'b1, 2'd3, 3'd3};
    vt[10] = '{6'd15, 6'd2, 16'h8000, 1'b0, 2'd3, 3'd3};
    vt[11] = '{6'd0,  6'd0, 16'h0000, 1'b0, 2'd0, 3'd0};
    vt[12] = '{6'd13, 6'd0, 16'h0000, 1'b1, 2'd3, 3'd3};
    vt[13] = '{6'd13, 6'd1, 16'h0000, 1'b0, 2'd3, 3'd3};
    vt[14] = '{6'd12, 6'd2, 16'h0000, 1'b1, 2'd3, 3'd3};
    vt[15] = '{6'd13, 6'd2, 16'h0000, 1'b0, 2'd3, 3'd3};
    vt[16] = '{6'd12, 6'd5, 16'h1234, 1'b0, 2'd3, 3'd3};
    vt[17] = '{6'd16, 6'd0, 16'h1234, 1'b0, 2'd3, 3'd4};
    vt[18] = '{6'd63, 6'd0, 16'h1234, 1'b0, 2'd3, 3'd7};
    vt[19] = '{6'd0,  6'd5, 16'h1234, 1'b0, 2'd0, 3'd0};
    vt[20] = '{6'd3,  6'd0, 16'h1234, 1'b0, 2'd0, 3'd0};
    vt[21] = '{6'd5,  6'd2, 16'h1234, 1'b1, 2'd1, 3'd1};
    vt[22] = '{6'd8,  6'd3, 16'h1234, 1'b1, 2'd2, 3'd2};
    vt[23] = '{6'd10, 6'd3, 16'h1234, 1'b0, 2'd2, 3'd2};
    vt[24] = '{6'd1,  6'd0, 16'h0100, 1'b0, 2'd0, 3'd0};
    vt[25] = '{6'd9,  6'd0, 16'h0100, 1'b1, 2'd2, 3'd2};
    vt[26] = '{6'd13, 6'd0, 16'h0100, 1'b1, 2'd3, 3'd3};

    reset_n = 1'b0; pix_valid = 1'b0; x_block = '0; y_block = '0;
    digits = 16'h1234; blink_mask = '0; cycle_en = 1'b0; frame_start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset valid", 8'(out_valid), 8'd0);
    chk("reset on", 8'(pixel_on), 8'd0);
    chk("reset color", 8'(color), 8'd0);
    chk("reset sel", 8'(digit_sel), 8'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back scan of row 0 with digits 4,3,2,1
    scan_exp = 16'b1010_1110_1110_0100;
    digits = 16'h1234; y_block = 6'd0;
    x_block = 6'd0; pix_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 1 || c == 18) begin
        chk($sformatf("scan c%0d valid", c), 8'(out_valid), 8'd0);
      end else begin
        chk($sformatf("scan x%0d valid", c - 2), 8'(out_valid), 8'd1);
        chk($sformatf("scan x%0d on", c - 2), 8'(pixel_on), 8'(scan_exp[15 - (c - 2)]));
        chk($sformatf("scan x%0d sel", c - 2), 8'(digit_sel), 8'((c - 2) / 4));
      end
      if (c < 16) begin
        x_block = 6'(c);
      end else begin
        pix_valid = 1'b0;
      end
    end

    for (int i = 0; i < NV; i++) begin
      digits = vt[i].dig;
      one_pixel($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].exp_on, vt[i].exp_sel,
                pal[vt[i].exp_pal]);
    end

    // Colour cycling: CYCLE_FRAMES=2, four enabled frames -> phase 2
    do_reset();
    digits = 16'h1234;
    cycle_en = 1'b1;
    pulse_frame(4);
    one_pixel("cyc cell0", 6'd0, 6'd0, 1'b1, 2'd0, pal[2]);
    one_pixel("cyc cell3", 6'd13, 6'd0, 1'b1, 2'd3, pal[5]);
    cycle_en = 1'b0;
    pulse_frame(4);
    one_pixel("hold cell0", 6'd0, 6'd0, 1'b1, 2'd0, pal[2]);
    one_pixel("hold cell3", 6'd13, 6'd0, 1'b1, 2'd3, pal[5]);

    // Blink: BLINK_FRAMES=3, only cell 1 masked
    do_reset();
    digits = 16'h1234; blink_mask = 4'b0010;
    one_pixel("blink pre c1", 6'd5, 6'd0, 1'b1, 2'd1, pal[1]);
    pulse_frame(3);
    one_pixel("blink on c1", 6'd5, 6'd0, 1'b0, 2'd1, pal[1]);
    one_pixel("blink on c0", 6'd0, 6'd0, 1'b1, 2'd0, pal[0]);
    one_pixel("blink on c2", 6'd9, 6'd0, 1'b1, 2'd2, pal[2]);
    pulse_frame(3);
    one_pixel("blink off c1", 6'd5, 6'd0, 1'b1, 2'd1, pal[1]);
    blink_mask = 4'b0000;

    // frame_start coincident with a pixel on the phase-wrap frame
    do_reset();
    digits = 16'h1234; cycle_en = 1'b1;
    pulse_frame(1);
    x_block = 6'd0; y_block = 6'd0; pix_valid = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; x_block = 6'd1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("coinc old valid", 8'(out_valid), 8'd1);
    chk("coinc old color", 8'(color), 8'(pal[0]));
    @(posedge clk); #1;
    chk("coinc new valid", 8'(out_valid), 8'd1);
    chk("coinc new color", 8'(color), 8'(pal[1]));
    cycle_en = 1'b0;

    // Asynchronous reset with both pipeline stages full
    @(posedge clk); #1;
    x_block = 6'd1; pix_valid = 1'b1;
    @(posedge clk); #1;
    x_block = 6'd2;
    @(posedge clk); #1;
    chk("mid full valid", 8'(out_valid), 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst valid", 8'(out_valid), 8'd0);
    chk("mid rst on", 8'(pixel_on), 8'd0);
    chk("mid rst color", 8'(color), 8'd0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst valid1", 8'(out_valid), 8'd0);
    @(posedge clk); #1;
    chk("post rst valid2", 8'(out_valid), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
